multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM sequencing the multicycle MIPS datapath (PC, IR, regfile, ALU, sign-extend, shift-left-2, memory).
//  Decodes opcode from IR, drives all mux selects and write enables one step per clock.
//  Stalls on memory via mem_ready handshake; flags unsupported opcodes.
// PARAMETERS
//  OPW       6   opcode width (instr[31:26])
//  STW       4   state register width
// PORTS
//  clk          in   1    rising-edge clock
//  reset        in   1    synchronous, active-high
//  opcode       in   6    IR[31:26]
//  mem_ready    in   1    memory completes access this cycle
//  pc_write     out  1    unconditional PC load
//  pc_write_cond out 1    PC load if ALU zero (BEQ)
//  i_or_d       out  1    mem addr: 0=PC, 1=ALUOut
//  mem_read     out  1    memory read request
//  mem_write    out  1    memory write request
//  ir_write     out  1    latch IR
//  mem_to_reg   out  1    WB data: 0=ALUOut, 1=MDR
//  reg_dst      out  1    dest: 0=rt, 1=rd
//  reg_write    out  1    regfile write
//  alu_src_a    out  1    0=PC, 1=A
//  alu_src_b    out  2    00=B, 01=4, 10=signext(imm), 11=signext(imm)<<2
//  alu_op       out  2    00=add, 01=sub, 10=funct-decoded
//  pc_source    out  2    00=ALU, 01=ALUOut, 10=jump target {PC[31:28],instr[25:0],2'b00}
//  illegal_op   out  1    one-cycle pulse, unsupported opcode in DECODE
//  state        out  4    current state (debug)
// BEHAVIOUR
//  Reset: state<=FETCH; while reset=1 every output is 0 (enables gated), state reads 0.
//  Outputs are pure functions of state (plus mem_ready gating ir_write/pc_write in FETCH).
//  States/transitions:
//   FETCH(0): mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00;
//     ir_write=pc_write=mem_ready. mem_ready=1 -> DECODE, else hold FETCH.
//   DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target -> ALUOut).
//     LW/SW -> MEMADR; R-type -> EXEC; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP (if enabled);
//     other -> FETCH with illegal_op=1 this cycle.
//   MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEMRD, SW -> MEMWR.
//   MEMRD(3): mem_read, i_or_d=1. mem_ready -> MEMWB else hold.
//   MEMWB(4): reg_write, reg_dst=0, mem_to_reg=1 -> FETCH.
//   MEMWR(5): mem_write, i_or_d=1. mem_ready -> FETCH else hold (mem_write held steady).
//   EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB.
//   RWB(7): reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
//   BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01 -> FETCH.
//   ADDIEX(9): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
//   ADDIWB(10): reg_write, reg_dst=0, mem_to_reg=0 -> FETCH.
//   JUMP(11): pc_write, pc_source=10 -> FETCH.
//  Unused state codes (12-15): all outputs 0, next=FETCH.
//  Latency (mem_ready tied 1): R 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3 cycles.
//  Opcode sampled only in DECODE/MEMADR; IR stable since only FETCH writes it.
//  Reset asserted in any state (incl. mid-stall): next cycle state=FETCH, no write enable seen.
// CONFIGURATION
//  MC_JUMP_EN defined: opcode 000010 -> JUMP state.
//  Undefined: JUMP state absent; 000010 treated as illegal (illegal_op pulse, -> FETCH).
// STRUCTURE
//  Package mips_ctrl_pkg: opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011,
//   OP_BEQ 000100, OP_ADDI 001000, OP_J 000010), state encodings, alu_src_b/alu_op/pc_source codes.
//  Sub-module mc_ctrl_decode: combinational state -> control-word decoder; FSM register/next-state in top.
// TESTING
//  reset 3 cycles, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7.
//  opcode=100011, mem_ready low 2 cycles in MEMRD -> state 3 held 3 cycles, mem_read=1 throughout; then 4 with mem_to_reg=1.
//  opcode=101011 -> 0,1,2,5,0; mem_write=1, i_or_d=1 only in 5; reg_write never 1.
//  opcode=000100 -> DECODE alu_src_b=11; BRANCH alu_op=01, pc_write_cond=1, pc_source=01.
//  opcode=000010: with MC_JUMP_EN -> state 11, pc_write=1, pc_source=10; without -> illegal_op=1 in DECODE, next FETCH.
//  reset raised during MEMWR stall -> next cycle state=0, mem_write=0; opcode=111111 -> illegal_op pulse exactly 1 cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encodings, mux-select codes and control word for the multicycle MIPS controller.
// MC_JUMP_EN enables the J instruction; without it opcode 000010 is reported as unsupported.
package mips_ctrl_pkg;

    localparam int OPW = 6;
    localparam int STW = 4;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    typedef enum logic [STW-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [OPW-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: return 1'b1;
`ifdef MC_JUMP_EN
            OP_J:    return 1'b1;
`else
            OP_J:    return 1'b0;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, all mux selects, enables and debug state out.
// master = controller side, slave = datapath/bench side.
interface multicycle_control_if;
    import mips_ctrl_pkg::*;

    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           pc_write;
    logic           pc_write_cond;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           mem_to_reg;
    logic           reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           illegal_op;
    logic [STW-1:0] state;

    // mem_ready is a completion strobe: an access request stays asserted until it is seen high.
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control word decoder (Moore outputs; mem_ready only gates FETCH updates).
// The JUMP control word exists only when MC_JUMP_EN is defined.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b  = SRCB_BRANCH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !op_supported(opcode);
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`ifdef MC_JUMP_EN
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register and next-state logic; control word from mc_ctrl_decode.
// Define MC_JUMP_EN to add the J instruction (DECODE -> JUMP -> FETCH).
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_o;

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    // IR only changes in FETCH, so opcode is stable wherever it is sampled here.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = ST_JUMP;
`endif
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                if (bus.opcode == OP_LW)      state_d = ST_MEMRD;
                else if (bus.opcode == OP_SW) state_d = ST_MEMWR;
                else                          state_d = ST_FETCH;
            end
            ST_MEMRD:  state_d = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  state_d = bus.mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_d = ST_RWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // While reset is high nothing may be enabled, even if the register still holds a mid-stall state.
    assign ctrl_o = reset ? '0 : ctrl;

    assign bus.pc_write      = ctrl_o.pc_write;
    assign bus.pc_write_cond = ctrl_o.pc_write_cond;
    assign bus.i_or_d        = ctrl_o.i_or_d;
    assign bus.mem_read      = ctrl_o.mem_read;
    assign bus.mem_write     = ctrl_o.mem_write;
    assign bus.ir_write      = ctrl_o.ir_write;
    assign bus.mem_to_reg    = ctrl_o.mem_to_reg;
    assign bus.reg_dst       = ctrl_o.reg_dst;
    assign bus.reg_write     = ctrl_o.reg_write;
    assign bus.alu_src_a     = ctrl_o.alu_src_a;
    assign bus.alu_src_b     = ctrl_o.alu_src_b;
    assign bus.alu_op        = ctrl_o.alu_op;
    assign bus.pc_source     = ctrl_o.pc_source;
    assign bus.illegal_op    = ctrl_o.illegal_op;
    assign bus.state         = reset ? '0 : state_q;

endmodule
